dec_scan_n: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder; successor to the combinational 2-to-4 decoder in the lab set.
- Direct mode: registered decode of `sel`.
- Scan mode: internal FSM steps through every code automatically, holding each one for a programmable dwell time, then signals completion.
- Used as a self-sequencing select/strobe generator for lab peripherals and as a self-checking stimulus source.

---
 rtl/dec_scan_n.sv | 160 ++++++++++++++++
 tb/tb_dec_scan_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_n.sv
// dec_scan_n -- registered N-to-2^N one-hot decoder with a self-sequencing scan mode.
//
// Direct mode (mode=0): y follows the one-hot decode of sel one cycle later,
// gated by en; cur_sel follows sel.
// Scan mode (mode=1): a start pulse (with en high) walks y through every code
// 0 .. 2**SEL_W-1, holding each code for DWELL enabled cycles, then spends one
// cycle in FIN with done high. en low pauses the scan (y blanked, position
// frozen); mode low aborts it back to direct decode without a done pulse.
//
// Optional build macro DEC_SCAN_CONT_EN: when defined, start held high at the
// end of the last code's dwell wraps the scan back to code 0 (done pulses for
// one cycle, busy stays high) instead of finishing.
//
// Parameters:
//   SEL_W  select width, output width is 2**SEL_W (1..6)
//   DWELL  enabled cycles each code is held while scanning (>= 1)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       output enable; pauses the scan when low
//   mode     0 = direct decode, 1 = scan
//   sel      code decoded in direct mode
//   start    starts a scan (mode=1, idle only)
//   y        registered one-hot output, bit i high = code i
//   cur_sel  code currently driven on y
//   busy     high while a scan is in progress
//   done     one-cycle pulse at the end of a scan
module dec_scan_n #(
   parameter int SEL_W = 2,
   parameter int DWELL = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic               start,
   output logic [2**SEL_W-1:0] y,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               busy,
   output logic               done
);

   localparam int OUT_W = 2**SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] LAST_CODE  = {SEL_W{1'b1}};
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] dwell_reg;

   // While scanning, cur_sel doubles as the scan position, so only the
   // following code needs to be formed here.
   logic [SEL_W-1:0] code_inc;
   logic [OUT_W-1:0] sel_onehot;
   logic [OUT_W-1:0] code_onehot;
   logic [OUT_W-1:0] next_onehot;

   assign code_inc = cur_sel + SEL_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi = gi + 1) begin : g_dec
         assign sel_onehot[gi]  = (sel      == SEL_W'(gi));
         assign code_onehot[gi] = (cur_sel  == SEL_W'(gi));
         assign next_onehot[gi] = (code_inc == SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         dwell_reg <= '0;
         y         <= '0;
         cur_sel   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!mode) begin
                  y       <= en ? sel_onehot : '0;
                  cur_sel <= sel;
               end else if (start && en) begin
                  state_reg <= SCAN;
                  dwell_reg <= '0;
                  y         <= OUT_W'(1);
                  cur_sel   <= '0;
                  busy      <= 1'b1;
               end else begin
                  y <= '0;
               end
            end

            SCAN: begin
               if (!mode) begin
                  // Abort: fall straight back to direct decode, no done pulse.
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  y         <= en ? sel_onehot : '0;
                  cur_sel   <= sel;
               end else if (!en) begin
                  // Paused: blank the output, keep position and dwell count.
                  y <= '0;
               end else if (dwell_reg == DWELL_LAST) begin
                  dwell_reg <= '0;
                  if (cur_sel == LAST_CODE) begin
`ifdef DEC_SCAN_CONT_EN
                     if (start) begin
                        y       <= OUT_W'(1);
                        cur_sel <= '0;
                        done    <= 1'b1;
                     end else begin
                        state_reg <= FIN;
                        y         <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                     end
`else
                     state_reg <= FIN;
                     y         <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
`endif
                  end else begin
                     cur_sel <= code_inc;
                     y       <= next_onehot;
                  end
               end else begin
                  dwell_reg <= dwell_reg + CNT_W'(1);
                  // Re-drive the current code so a resume after a pause
                  // restores it.
                  y <= code_onehot;
               end
            end

            FIN: begin
               // start is not looked at here; IDLE must sample it again.
               state_reg <= IDLE;
               y         <= '0;
            end

            default: begin
               state_reg <= IDLE;
               y         <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dec_scan_n.sv
// Testbench for dec_scan_n (SEL_W=2, DWELL=3). A progress-based reference
// model (scan position = number of enabled scan edges) predicts every output
// after every clock edge; directed phases follow the test plan and are
// followed by a randomized phase.
module tb_dec_scan_n;

   localparam int SEL_W  = 2;
   localparam int DWELL  = 3;
   localparam int NCODES = 2**SEL_W;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic               start;
   logic [NCODES-1:0]  y;
   logic [SEL_W-1:0]   cur_sel;
   logic               busy;
   logic               done;

   dec_scan_n #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .start(start), .y(y), .cur_sel(cur_sel), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state: phase 0 = idle, 1 = scanning, 2 = finishing.
   int               m_phase;
   int               m_p;
   logic [63:0]      m_y;
   logic [SEL_W-1:0] m_cs;
   logic             m_busy;
   logic             m_done;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_p     = 0;
      m_y     = '0;
      m_cs    = '0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      case (m_phase)
         0: begin
            if (!mode) begin
               m_y  = en ? (64'd1 << sel) : 64'd0;
               m_cs = sel;
            end else if (start && en) begin
               m_phase = 1;
               m_p     = 0;
               m_y     = 64'd1;
               m_cs    = '0;
               m_busy  = 1'b1;
            end else begin
               m_y = '0;
            end
         end
         1: begin
            if (!mode) begin
               m_phase = 0;
               m_busy  = 1'b0;
               m_y     = en ? (64'd1 << sel) : 64'd0;
               m_cs    = sel;
            end else if (!en) begin
               m_y = '0;
            end else begin
               m_p++;
               if (m_p == NCODES * DWELL) begin
`ifdef DEC_SCAN_CONT_EN
                  if (start) begin
                     m_p    = 0;
                     m_y    = 64'd1;
                     m_cs   = '0;
                     m_done = 1'b1;
                  end else
`endif
                  begin
                     m_phase = 2;
                     m_y     = '0;
                     m_busy  = 1'b0;
                     m_done  = 1'b1;
                  end
               end else begin
                  m_cs = SEL_W'(m_p / DWELL);
                  m_y  = 64'd1 << m_cs;
               end
            end
         end
         default: begin
            m_phase = 0;
            m_y     = '0;
         end
      endcase
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".y"},       64'(y),       m_y);
      check_val({tag, ".cur_sel"}, 64'(cur_sel), 64'(m_cs));
      check_val({tag, ".busy"},    64'(busy),    64'(m_busy));
      check_val({tag, ".done"},    64'(done),    64'(m_done));
      check_val({tag, ".onehot0"}, 64'($onehot0(y)), 64'd1);
   endtask

   // One clock edge: model follows the same sampled inputs, outputs are
   // compared 1 time unit after the edge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_outputs(tag);
      $display("%-8s cyc=%0d rst_n=%0b mode=%0b en=%0b start=%0b sel=%0d | y=%b cur_sel=%0d busy=%0b done=%0b",
               tag, cyc, rst_n, mode, en, start, sel, y, cur_sel, busy, done);
   endtask

   task automatic start_scan(input string tag);
      mode  = 1'b1;
      en    = 1'b1;
      start = 1'b1;
      step(tag);
      start = 1'b0;
   endtask

   // Run until the scan has reached the given progress (or has ended).
   task automatic run_to_progress(input string tag, input int target);
      int k;
      for (k = 0; k < 100; k++) begin
         if (m_phase != 1 || m_p >= target) break;
         step(tag);
      end
      check_val({tag, ".reach_bound"}, 64'(k < 100), 64'd1);
   endtask

   task automatic run_to_idle(input string tag);
      int k;
      for (k = 0; k < 100; k++) begin
         if (m_phase == 0) break;
         step(tag);
      end
      check_val({tag, ".idle_bound"}, 64'(k < 100), 64'd1);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs({tag, ".async"});
      $display("%-8s async reset mid-cycle | y=%b cur_sel=%0d busy=%0b done=%0b",
               tag, y, cur_sel, busy, done);
      step(tag);
      step(tag);
      rst_n = 1'b1;
   endtask

   int busy_cycles;

   initial begin
      model_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      mode  = 1'b0;
      sel   = '0;
      start = 1'b0;

      // Reset, then direct decode sweep.
      #1;
      check_outputs("rst0");
      step("rst");
      step("rst");
      rst_n = 1'b1;
      for (int i = 0; i < NCODES; i++) begin
         sel = SEL_W'(i);
         step("direct");
      end

      // Direct mode enable gating.
      sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         en = (i % 2 == 0);
         step("den");
      end
      en = 1'b1;

      // Full scan, with an independent busy-length check.
      start_scan("scan");
      busy_cycles = 1;
      for (int i = 0; i < NCODES * DWELL + 2; i++) begin
         step("scan");
         if (busy) busy_cycles++;
      end
      check_val("scan.busy_len", 64'(busy_cycles), 64'(NCODES * DWELL));

      // Pause at code 2 after one dwell cycle.
      step("gap");
      start_scan("pause");
      run_to_progress("pause", 2 * DWELL);
      en = 1'b0;
      repeat (5) step("pause");
      en = 1'b1;
      run_to_idle("pause");
      step("pause");

      // Abort at code 1, then a start while busy.
      start_scan("abort");
      run_to_progress("abort", DWELL);
      mode = 1'b0;
      sel  = 2'd3;
      step("abort");
      step("abort");
      start_scan("busyst");
      step("busyst");
      start = 1'b1;
      repeat (3) step("busyst");
      start = 1'b0;
      run_to_idle("busyst");

      // start held high through the end of the scan.
      mode  = 1'b1;
      start = 1'b1;
      repeat (2 * NCODES * DWELL + 6) step("hold");
      start = 1'b0;
      run_to_idle("hold");

      // Asynchronous reset mid-scan.
      start_scan("arst");
      repeat (4) step("arst");
      async_reset("arst");
      step("arst");

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         mode  = ($urandom_range(0, 9) != 0);
         en    = ($urandom_range(0, 7) != 0);
         start = ($urandom_range(0, 3) == 0);
         sel   = SEL_W'($urandom);
         step("rand");
         if ($urandom_range(0, 99) == 0) async_reset("rrst");
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
